// File: rtl/m20k_4096x4_arbiter_pkg.sv
// Shared types and constants for the dual-port M20K arbiter.
package m20k_4096x4_arbiter_pkg;

    localparam int NREQ_DEF = 4;
    localparam int AW_DEF   = 12;
    localparam int DW_DEF   = 4;

    // Requester index width sized for the largest supported NREQ (8).
    localparam int IDX_W = 3;

    typedef logic [IDX_W-1:0] idx_t;

    // Records which requester a memory port served last cycle, so the
    // registered Q data can be steered back to the right RDATA slot.
    typedef struct packed {
        logic valid;
        idx_t idx;
    } owner_tag_t;

    // Ceiling log2 with a floor of 1 bit, used to size the round-robin pointer.
    function automatic int log2_ceil(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/m20k_4096x4_arbiter_if.sv
// Requester bus plus dual memory-port bus of the M20K arbiter.
interface m20k_4096x4_arbiter_if
    import m20k_4096x4_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) ();

    logic [NREQ-1:0]    REQ;
    logic [NREQ-1:0]    REQ_WE;
    logic [NREQ*AW-1:0] REQ_ADDR;
    logic [NREQ*DW-1:0] REQ_WDATA;
    logic [NREQ-1:0]    GNT;
    logic [NREQ-1:0]    RVALID;
    logic [NREQ*DW-1:0] RDATA;
    logic [AW-1:0]      A0;
    logic [AW-1:0]      A1;
    logic [DW-1:0]      D0;
    logic [DW-1:0]      D1;
    logic               CE0;
    logic               CE1;
    logic               WE0;
    logic               WE1;
    logic [DW-1:0]      Q0;
    logic [DW-1:0]      Q1;

    // The arbiter side.
    modport slave (
        input  REQ, REQ_WE, REQ_ADDR, REQ_WDATA, Q0, Q1,
        output GNT, RVALID, RDATA, A0, A1, D0, D1, CE0, CE1, WE0, WE1
    );

    // Requesters and the RAM together.
    modport master (
        output REQ, REQ_WE, REQ_ADDR, REQ_WDATA, Q0, Q1,
        input  GNT, RVALID, RDATA, A0, A1, D0, D1, CE0, CE1, WE0, WE1
    );

endinterface

// File: rtl/m20k_4096x4_arbiter_rr_pick2.sv
// Combinational two-winner round-robin picker: scans from ptr upward
// (wrapping) and reports the first and second active requesters.
module m20k_4096x4_arbiter_rr_pick2
    import m20k_4096x4_arbiter_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int PW   = log2_ceil(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            first_vld,
    output idx_t            first_idx,
    output logic            second_vld,
    output idx_t            second_idx
);

    // Walk the requesters in priority order starting at ptr.
    always_comb begin
        int              idx;
        logic [NREQ-1:0] sh;
        // NOTE: every output gets a default before any conditional update,
        // otherwise paths that skip an assignment infer latches.
        first_vld  = 1'b0;
        first_idx  = '0;
        second_vld = 1'b0;
        second_idx = '0;
        idx        = 0;
        sh         = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            sh = req >> idx;
            if (sh[0]) begin
                if (!first_vld) begin
                    first_vld = 1'b1;
                    first_idx = idx_t'(idx);
                end else if (!second_vld) begin
                    second_vld = 1'b1;
                    second_idx = idx_t'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/m20k_4096x4_arbiter.sv
// Arbitrates NREQ requesters onto the two ports of an M20K RAM: up to two
// grants per cycle, round-robin fairness, same-address write conflicts
// serialised, and read data steered back one cycle later via owner tags.
module m20k_4096x4_arbiter
    import m20k_4096x4_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input logic                   CLK,
    input logic                   RSTN,
    m20k_4096x4_arbiter_if.slave  bus
);

    localparam int PW = log2_ceil(NREQ);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic            first_vld;
    logic            second_vld;
    idx_t            first_idx;
    idx_t            second_idx;
    logic [NREQ-1:0] sel_a;
    logic [NREQ-1:0] sel_b;
    logic [AW-1:0]   addr_a;
    logic [AW-1:0]   addr_b;
    logic [DW-1:0]   wd_a;
    logic [DW-1:0]   wd_b;
    logic            we_a;
    logic            we_b;
    logic            conflict;
    logic            gnt_a;
    logic            gnt_b;
    owner_tag_t      tag0;
    owner_tag_t      tag1;

    m20k_4096x4_arbiter_rr_pick2 #(.NREQ(NREQ)) u_pick (
        .req        (bus.REQ),
        .ptr        (ptr),
        .first_vld  (first_vld),
        .first_idx  (first_idx),
        .second_vld (second_vld),
        .second_idx (second_idx)
    );

    // Unpack the two candidates' request fields.
    assign sel_a  = NREQ'(1) << first_idx;
    assign sel_b  = NREQ'(1) << second_idx;
    assign addr_a = AW'(bus.REQ_ADDR >> (int'(first_idx) * AW));
    assign addr_b = AW'(bus.REQ_ADDR >> (int'(second_idx) * AW));
    assign wd_a   = DW'(bus.REQ_WDATA >> (int'(first_idx) * DW));
    assign wd_b   = DW'(bus.REQ_WDATA >> (int'(second_idx) * DW));
    assign we_a   = |(bus.REQ_WE & sel_a);
    assign we_b   = |(bus.REQ_WE & sel_b);

    // Same address with any write would hit undefined mixed-port RAM
    // behaviour, so the second candidate waits a cycle.
    assign conflict = first_vld && second_vld && (addr_a == addr_b) && (we_a || we_b);

    // Grants are suppressed while reset is held so nothing reaches the RAM.
    assign gnt_a = RSTN && first_vld;
    assign gnt_b = RSTN && second_vld && !conflict;

    // Pointer moves just past the last requester granted this cycle.
    always_comb begin
        int n;
        n       = 0;
        ptr_nxt = ptr;
        if (gnt_b) begin
            n       = int'(second_idx) + 1;
            if (n >= NREQ) n = 0;
            ptr_nxt = PW'(n);
        end else if (gnt_a) begin
            n       = int'(first_idx) + 1;
            if (n >= NREQ) n = 0;
            ptr_nxt = PW'(n);
        end
    end

    // Drive grants and both memory ports; idle ports stay fully zero.
    always_comb begin
        bus.GNT = '0;
        bus.CE0 = 1'b0;
        bus.WE0 = 1'b0;
        bus.A0  = '0;
        bus.D0  = '0;
        bus.CE1 = 1'b0;
        bus.WE1 = 1'b0;
        bus.A1  = '0;
        bus.D1  = '0;
        if (gnt_a) begin
            bus.CE0 = 1'b1;
            bus.WE0 = we_a;
            bus.A0  = addr_a;
            bus.D0  = wd_a;
        end
        if (gnt_b) begin
            bus.CE1 = 1'b1;
            bus.WE1 = we_b;
            bus.A1  = addr_b;
            bus.D1  = wd_b;
        end
        bus.GNT = (gnt_a ? sel_a : '0) | (gnt_b ? sel_b : '0);
    end

    // Round-robin pointer and per-port owner tags for reads in flight.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ptr  <= '0;
            tag0 <= '0;
            tag1 <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            ptr  <= ptr_nxt;
            tag0 <= '{valid: gnt_a && !we_a, idx: first_idx};
            tag1 <= '{valid: gnt_b && !we_b, idx: second_idx};
        end
    end

    // Steer each port's read data to the slot named by its owner tag.
    always_comb begin
        bus.RVALID = '0;
        bus.RDATA  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (tag0.valid && tag0.idx == idx_t'(i)) begin
                bus.RVALID[i]         = 1'b1;
                bus.RDATA[i*DW +: DW] = bus.Q0;
            end else if (tag1.valid && tag1.idx == idx_t'(i)) begin
                bus.RVALID[i]         = 1'b1;
                bus.RDATA[i*DW +: DW] = bus.Q1;
            end
        end
    end

endmodule

// File: tb/tb_m20k_4096x4_arbiter.sv
// Directed self-checking bench for m20k_4096x4_arbiter with a behavioural
// dual-port RAM attached to the memory ports.
module tb_m20k_4096x4_arbiter;

    logic CLK;
    logic RSTN;
    int   n_chk;
    int   n_fail;

    m20k_4096x4_arbiter_if #(.NREQ(4), .AW(12), .DW(4)) bus ();

    m20k_4096x4_arbiter #(.NREQ(4), .AW(12), .DW(4)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    logic [3:0] mem [0:4095];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural RAM: registered read data, write at the grant edge.
    always @(posedge CLK) begin
        if (bus.CE0 && !bus.WE0) bus.Q0 <= mem[bus.A0];
        if (bus.CE1 && !bus.WE1) bus.Q1 <= mem[bus.A1];
        if (bus.CE0 && bus.WE0) mem[bus.A0] = bus.D0;
        if (bus.CE1 && bus.WE1) mem[bus.A1] = bus.D1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [11:0] addr,
                           input logic [3:0] wd);
        bus.REQ[i]               = 1'b1;
        bus.REQ_WE[i]            = we;
        bus.REQ_ADDR[i*12 +: 12] = addr;
        bus.REQ_WDATA[i*4 +: 4]  = wd;
    endtask

    task automatic clear_req();
        bus.REQ       = '0;
        bus.REQ_WE    = '0;
        bus.REQ_ADDR  = '0;
        bus.REQ_WDATA = '0;
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        clear_req();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 12'h100 + 12'(i), 4'h0);
        #2;
        n_chk++; if (bus.GNT !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt: got %b want 0000", bus.GNT); end
        n_chk++; if (bus.CE0 !== 1'b0 || bus.CE1 !== 1'b0) begin n_fail++; $display("FAIL rst_ce: got %b%b want 00", bus.CE0, bus.CE1); end
        n_chk++; if (bus.WE0 !== 1'b0 || bus.WE1 !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b%b want 00", bus.WE0, bus.WE1); end
        n_chk++; if (bus.RVALID !== 4'b0000) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0000", bus.RVALID); end
        @(negedge CLK);
        RSTN = 1'b1;
        #1;
        n_chk++; if (bus.GNT !== 4'b0011) begin n_fail++; $display("FAIL first_gnt: got %b want 0011", bus.GNT); end
        n_chk++; if (bus.A0 !== 12'h100 || bus.A1 !== 12'h101) begin n_fail++; $display("FAIL first_addr: got %h/%h want 100/101", bus.A0, bus.A1); end
        n_chk++; if (bus.CE0 !== 1'b1 || bus.CE1 !== 1'b1 || bus.WE0 !== 1'b0) begin n_fail++; $display("FAIL first_ce: got ce %b%b we0 %b want 11/0", bus.CE0, bus.CE1, bus.WE0); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_g;
        logic [3:0]  exp_rv;
        logic [15:0] exp_rd;
        exp_g = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_rv = exp_g;
            exp_g  = ~exp_g;
            exp_rd = (exp_rv == 4'b0011) ? 16'h0065 : 16'h8700;
            n_chk++; if (bus.GNT !== exp_g) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, bus.GNT, exp_g); end
            n_chk++; if (bus.RVALID !== exp_rv) begin n_fail++; $display("FAIL rr_rvalid[%0d]: got %b want %b", k, bus.RVALID, exp_rv); end
            n_chk++; if (bus.RDATA !== exp_rd) begin n_fail++; $display("FAIL rr_rdata[%0d]: got %h want %h", k, bus.RDATA, exp_rd); end
        end
        tick();
        clear_req();
        #1;
        n_chk++; if (bus.RVALID !== 4'b0011 || bus.RDATA !== 16'h0065) begin n_fail++; $display("FAIL rr_last: got %b/%h want 0011/0065", bus.RVALID, bus.RDATA); end
        n_chk++; if (bus.GNT !== 4'b0000 || bus.CE0 !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got gnt %b ce0 %b want 0000/0", bus.GNT, bus.CE0); end
    endtask

    // PTR is 2 on entry.
    task automatic test_write_read();
        set_req(0, 1'b1, 12'h123, 4'hA);
        #1;
        n_chk++; if (bus.GNT !== 4'b0001) begin n_fail++; $display("FAIL wr_gnt: got %b want 0001", bus.GNT); end
        n_chk++; if (bus.CE0 !== 1'b1 || bus.WE0 !== 1'b1 || bus.A0 !== 12'h123 || bus.D0 !== 4'hA) begin n_fail++; $display("FAIL wr_port0: got ce %b we %b a %h d %h want 1/1/123/a", bus.CE0, bus.WE0, bus.A0, bus.D0); end
        n_chk++; if (bus.CE1 !== 1'b0 || bus.A1 !== 12'h000) begin n_fail++; $display("FAIL wr_port1_idle: got ce %b a %h want 0/000", bus.CE1, bus.A1); end
        tick();
        set_req(0, 1'b0, 12'h123, 4'h0);
        #1;
        n_chk++; if (bus.RVALID !== 4'b0000) begin n_fail++; $display("FAIL wr_no_rvalid: got %b want 0000", bus.RVALID); end
        n_chk++; if (bus.GNT !== 4'b0001 || bus.WE0 !== 1'b0) begin n_fail++; $display("FAIL rd_gnt: got %b we0 %b want 0001/0", bus.GNT, bus.WE0); end
        tick();
        clear_req();
        #1;
        n_chk++; if (bus.RVALID !== 4'b0001 || bus.RDATA !== 16'h000A) begin n_fail++; $display("FAIL rd_data: got %b/%h want 0001/000a", bus.RVALID, bus.RDATA); end
        tick();
        n_chk++; if (bus.RVALID !== 4'b0000) begin n_fail++; $display("FAIL rd_one_cycle: got %b want 0000", bus.RVALID); end
    endtask

    // PTR is 1 on entry.
    task automatic test_conflict();
        set_req(1, 1'b1, 12'h7FF, 4'h5);
        set_req(2, 1'b0, 12'h7FF, 4'h0);
        #1;
        n_chk++; if (bus.GNT !== 4'b0010) begin n_fail++; $display("FAIL cf_gnt: got %b want 0010", bus.GNT); end
        n_chk++; if (bus.CE1 !== 1'b0 || bus.WE0 !== 1'b1 || bus.A0 !== 12'h7FF) begin n_fail++; $display("FAIL cf_ports: got ce1 %b we0 %b a0 %h want 0/1/7ff", bus.CE1, bus.WE0, bus.A0); end
        tick();
        bus.REQ[1] = 1'b0;
        #1;
        n_chk++; if (bus.GNT !== 4'b0100 || bus.A0 !== 12'h7FF || bus.WE0 !== 1'b0) begin n_fail++; $display("FAIL cf_second: got %b a0 %h we0 %b want 0100/7ff/0", bus.GNT, bus.A0, bus.WE0); end
        tick();
        clear_req();
        #1;
        n_chk++; if (bus.RVALID !== 4'b0100 || bus.RDATA !== 16'h0500) begin n_fail++; $display("FAIL cf_rdata: got %b/%h want 0100/0500", bus.RVALID, bus.RDATA); end
    endtask

    // PTR is 3 on entry.
    task automatic test_routing();
        set_req(3, 1'b0, 12'h103, 4'h0);
        set_req(0, 1'b0, 12'h100, 4'h0);
        #1;
        n_chk++; if (bus.GNT !== 4'b1001) begin n_fail++; $display("FAIL rt_gnt: got %b want 1001", bus.GNT); end
        n_chk++; if (bus.A0 !== 12'h103 || bus.A1 !== 12'h100) begin n_fail++; $display("FAIL rt_addr: got %h/%h want 103/100", bus.A0, bus.A1); end
        tick();
        clear_req();
        #1;
        n_chk++; if (bus.RVALID !== 4'b1001 || bus.RDATA !== 16'h8005) begin n_fail++; $display("FAIL rt_rdata: got %b/%h want 1001/8005", bus.RVALID, bus.RDATA); end
    endtask

    // PTR is 1 on entry; two reads of one address must both be granted.
    task automatic test_same_addr_reads();
        set_req(1, 1'b0, 12'h7FF, 4'h0);
        set_req(2, 1'b0, 12'h7FF, 4'h0);
        #1;
        n_chk++; if (bus.GNT !== 4'b0110 || bus.CE1 !== 1'b1) begin n_fail++; $display("FAIL rr_same_gnt: got %b ce1 %b want 0110/1", bus.GNT, bus.CE1); end
        tick();
        clear_req();
        #1;
        n_chk++; if (bus.RVALID !== 4'b0110 || bus.RDATA !== 16'h0550) begin n_fail++; $display("FAIL rr_same_rdata: got %b/%h want 0110/0550", bus.RVALID, bus.RDATA); end
    endtask

    // PTR is 3 on entry; a lone requester reads every cycle.
    task automatic test_back_to_back();
        logic [15:0] exp_rd;
        for (int k = 0; k < 3; k++) begin
            set_req(2, 1'b0, 12'h100 + 12'(k), 4'h0);
            #1;
            n_chk++; if (bus.GNT !== 4'b0100 || bus.A0 !== 12'h100 + 12'(k)) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %b a0 %h want 0100", k, bus.GNT, bus.A0); end
            if (k > 0) begin
                exp_rd = {4'h0, 4'(4 + k), 8'h00};
                n_chk++; if (bus.RVALID !== 4'b0100 || bus.RDATA !== exp_rd) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %b/%h want 0100/%h", k, bus.RVALID, bus.RDATA, exp_rd); end
            end
            tick();
        end
        clear_req();
        #1;
        n_chk++; if (bus.RVALID !== 4'b0100 || bus.RDATA !== 16'h0700) begin n_fail++; $display("FAIL b2b_last: got %b/%h want 0100/0700", bus.RVALID, bus.RDATA); end
    endtask

    task automatic test_reset_mid_read();
        set_req(1, 1'b0, 12'h101, 4'h0);
        #1;
        n_chk++; if (bus.GNT !== 4'b0010) begin n_fail++; $display("FAIL mid_gnt: got %b want 0010", bus.GNT); end
        tick();
        clear_req();
        RSTN = 1'b0;
        #1;
        n_chk++; if (bus.RVALID !== 4'b0000) begin n_fail++; $display("FAIL mid_rvalid_async: got %b want 0000", bus.RVALID); end
        tick();
        RSTN = 1'b1;
        #1;
        n_chk++; if (bus.RVALID !== 4'b0000) begin n_fail++; $display("FAIL mid_rvalid_after: got %b want 0000", bus.RVALID); end
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 12'h100 + 12'(i), 4'h0);
        #1;
        n_chk++; if (bus.GNT !== 4'b0011) begin n_fail++; $display("FAIL mid_ptr_zero: got %b want 0011", bus.GNT); end
        // Reset asserted while a read grant is live: the grant must vanish.
        RSTN = 1'b0;
        #1;
        n_chk++; if (bus.GNT !== 4'b0000 || bus.CE0 !== 1'b0 || bus.CE1 !== 1'b0) begin n_fail++; $display("FAIL rst_kill_gnt: got %b ce %b%b want 0000/00", bus.GNT, bus.CE0, bus.CE1); end
        tick();
        clear_req();
        RSTN = 1'b1;
        #1;
        tick();
        n_chk++; if (bus.RVALID !== 4'b0000) begin n_fail++; $display("FAIL rst_kill_rvalid: got %b want 0000", bus.RVALID); end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int a = 0; a < 4096; a++) mem[a] = 4'h0;
        for (int i = 0; i < 4; i++) mem[12'h100 + i] = 4'(5 + i);
        test_reset();
        test_round_robin();
        test_write_read();
        test_conflict();
        test_routing();
        test_same_addr_reads();
        test_back_to_back();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/m20k_4096x4_arbiter.md
M20K_4096X4_ARBITER -- requirements
Module: m20k_4096x4_arbiter

Interface
REQ-001 Parameter NREQ, default 4, meaning the number of requesters sharing the memory (range 2..8).
REQ-002 Parameter AW, default 12, meaning the address width (4096 words).
REQ-003 Parameter DW, default 4, meaning the data width.
REQ-004 Port CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 Port RSTN  input  1  asynchronous, active-low reset.
REQ-006 Port REQ  input  NREQ  per-requester access request, held until granted.
REQ-007 Port REQ_WE  input  NREQ  per-requester write flag (1 = write, 0 = read).
REQ-008 Port REQ_ADDR  input  NREQ*AW  packed addresses; requester i occupies bits [i*AW +: AW].
REQ-009 Port REQ_WDATA  input  NREQ*DW  packed write data, same packing.
REQ-010 Port GNT  output  NREQ  per-requester grant, combinational in the request cycle.
REQ-011 Port RVALID  output  NREQ  per-requester read-data valid.
REQ-012 Port RDATA  output  NREQ*DW  packed read data.
REQ-013 Ports A0/A1  output  AW each  memory port 0/1 addresses.
REQ-014 Ports D0/D1  output  DW each  memory port 0/1 write data.
REQ-015 Ports CE0/CE1, WE0/WE1  output  1 each  memory port enables and write enables.
REQ-016 Ports Q0/Q1  input  DW each  memory port read data, valid the cycle after a read is issued.

Function
REQ-017 Each cycle, the block SHALL grant at most two requests, scanning round-robin from pointer PTR.
REQ-018 The first granted requester SHALL drive port 0 and the second SHALL drive port 1.
REQ-019 CEn SHALL be 1 only for a port carrying a grant, and WEn SHALL equal that requester's REQ_WE.
- An idle port drives CE=0, WE=0, and zero address/data.
REQ-020 Address conflict: if the two candidates have equal addresses and either is a write, only the first SHALL be granted.
- The second waits; mixed-port read-during-write behaviour is undefined in the RAM.
REQ-021 PTR SHALL advance to (last granted index + 1) mod NREQ and SHALL hold when there is no grant.
REQ-022 GNT[i] SHALL be asserted only when REQ[i]=1.
- A requester SHALL drop or change REQ only after GNT.
REQ-023 Read latency: a read granted in cycle t SHALL produce RVALID[i]=1 with RDATA[i] = Qport in cycle t+1, for exactly one cycle.
REQ-024 A per-port registered owner tag (valid + index) SHALL route Q0/Q1 to the correct RDATA slot.
- RDATA of a non-valid slot SHALL be 0.
REQ-025 Writes SHALL produce no RVALID; a write is complete at the grant edge.
REQ-026 Back-to-back grants to the same requester in consecutive cycles SHALL be supported.
- With at most one requester active, that requester gets full throughput: one access per cycle.
REQ-027 When all NREQ requesters are continuously active and conflict-free, each SHALL be granted within ceil(NREQ/2) cycles.

Reset
REQ-028 On RSTN=0, PTR SHALL be 0, owner tags invalid, and RVALID all 0, immediately and asynchronously.
REQ-029 During reset, GNT, CE0, CE1, WE0 and WE1 SHALL be 0.
REQ-030 A read granted in the cycle reset asserts SHALL produce no RVALID after reset releases.

Structure
REQ-031 A shared package SHALL hold the owner-tag struct (valid, index), the default AW/DW/NREQ constants, and a log2 function.
REQ-032 One sub-module, rr_pick2, SHALL implement the combinational two-winner round-robin selection from (request vector, PTR).
- The conflict check and PTR update remain in the top module.

Verification
REQ-033 Reset: RSTN low with REQ=4'b1111 -> GNT=0, CE0=CE1=0, RVALID=0.
- After release, the first cycle grants requester 0 on port 0 and requester 1 on port 1.
REQ-034 Write/read: req0 writes addr 0x123 data 0xA (granted) -> req0 reads 0x123 next cycle -> RVALID[0]=1 with RDATA=0xA one cycle later.
REQ-035 Round-robin: REQ=4'b1111 held, all reads, distinct addresses -> grants {0,1}, {2,3}, {0,1}, ...; no requester is starved more than 2 cycles.
REQ-036 Conflict: req1 writes 0x7FF and req2 reads 0x7FF with PTR=1 -> only req1 is granted; req2 is granted the next cycle and reads the new value.
REQ-037 Routing: req3 and req0 read in the same cycle with PTR=3 -> port 0 serves req3 and port 1 serves req0; RVALID=4'b1001 the next cycle with the data correctly steered.
REQ-038 Reset mid-read: assert RSTN=0 in the cycle after a read grant -> RVALID stays 0, and PTR=0 after release.
